// File: rtl/bp_pkg.sv
// +----------------------------------------------------------------------+
// | bp_pkg: opcodes, 2-bit counter encodings, FSM states, counter helpers |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_btb.sv
// +----------------------------------------------------------------------+
// | bp_btb: direct-mapped tagged BTB, one-entry-per-cycle clear port,     |
// | combinational read that returns pre-write contents. Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module bp_btb #(
    parameter int BTB_BITS = 6
) (
    input  logic                clk,
    input  logic                clr_i,
    input  logic [BTB_BITS-1:0] clr_idx_i,
    input  logic [31:0]         rd_pc_i,
    output logic                rd_hit_o,
    output logic [31:0]         rd_target_o,
    input  logic                wr_en_i,
    input  logic [31:0]         wr_pc_i,
    input  logic [31:0]         wr_target_i
);

    localparam int DEPTH = 1 << BTB_BITS;
    localparam int TAG_W = 30 - BTB_BITS;

    logic              valid_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [31:0]       target_q [DEPTH];

    logic [BTB_BITS-1:0] w_rd_idx;
    logic [BTB_BITS-1:0] w_wr_idx;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [TAG_W-1:0]    w_wr_tag;
    logic                w_unused_lsbs;

    assign w_rd_idx      = rd_pc_i[BTB_BITS+1:2];
    assign w_wr_idx      = wr_pc_i[BTB_BITS+1:2];
    assign w_rd_tag      = rd_pc_i[31:BTB_BITS+2];
    assign w_wr_tag      = wr_pc_i[31:BTB_BITS+2];
    assign w_unused_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    // Only the valid bit needs clearing; tag/target are don't-care until written.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            valid_q[clr_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            valid_q[w_wr_idx]  <= 1'b1;
            tag_q[w_wr_idx]    <= w_wr_tag;
            target_q[w_wr_idx] <= wr_target_i;
        end
    end

    assign rd_hit_o    = valid_q[w_rd_idx] && (tag_q[w_rd_idx] == w_rd_tag);
    assign rd_target_o = target_q[w_rd_idx];

endmodule

`default_nettype wire

// File: rtl/branch_predictor_gshare.sv
// +----------------------------------------------------------------------+
// | branch_predictor_gshare: gshare/gselect PHT + tagged BTB with         |
// | speculative GHR and misprediction repair. Revision: 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

module branch_predictor_gshare
    import bp_pkg::*;
#(
    parameter int PHT_BITS = 10,
    parameter int GHR_BITS = 8,
    parameter int BTB_BITS = 6,
    parameter int MODE     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lookup_valid_i,
    input  logic [31:0]         lookup_pc_i,
    input  logic [6:0]          opcode_i,
    output logic                ready_o,
    output logic                pred_valid_o,
    output logic                pred_taken_o,
    output logic                pred_hit_o,
    output logic [31:0]         pred_target_o,
    output logic [GHR_BITS-1:0] pred_ghr_o,
    input  logic                update_i,
    input  logic [6:0]          update_opcode_i,
    input  logic [31:0]         update_pc_i,
    input  logic [31:0]         update_target_i,
    input  logic                update_taken_i,
    input  logic [GHR_BITS-1:0] update_ghr_i,
    input  logic                update_mispredict_i
);

    localparam int INIT_BITS = (PHT_BITS > BTB_BITS) ? PHT_BITS : BTB_BITS;
    localparam int PHT_DEPTH = 1 << PHT_BITS;

    bp_state_e            state_q;
    logic [INIT_BITS-1:0] init_idx_q;
    logic                 ready_q;
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic [1:0]           pht_q [PHT_DEPTH];

    logic                 pred_valid_q, pred_taken_q, pred_hit_q;
    logic [31:0]          pred_target_q;
    logic [GHR_BITS-1:0]  pred_ghr_q;

    logic [PHT_BITS-1:0]  w_lk_idx, w_up_idx;
    logic                 w_accept, w_upd, w_is_br, w_is_jal;
    logic                 w_btb_hit, w_taken;
    logic [31:0]          w_btb_target, w_target;
    logic [1:0]           w_lk_ctr;

    generate
        if (MODE == 0) begin : g_gshare
            assign w_lk_idx = lookup_pc_i[PHT_BITS+1:2] ^ PHT_BITS'(ghr_q);
            assign w_up_idx = update_pc_i[PHT_BITS+1:2] ^ PHT_BITS'(update_ghr_i);
        end else begin : g_gselect
            assign w_lk_idx = {ghr_q, lookup_pc_i[PHT_BITS-GHR_BITS+1:2]};
            assign w_up_idx = {update_ghr_i, update_pc_i[PHT_BITS-GHR_BITS+1:2]};
        end
    endgenerate

    assign w_accept = lookup_valid_i & ready_q;
    assign w_upd    = update_i & ready_q;
    assign w_is_br  = (opcode_i == OPC_BRANCH);
    assign w_is_jal = (opcode_i == OPC_JAL);
    assign w_lk_ctr = pht_q[w_lk_idx];
    assign w_taken  = (w_is_br & w_btb_hit & w_lk_ctr[1]) | (w_is_jal & w_btb_hit);
    assign w_target = w_taken ? w_btb_target : lookup_pc_i + 32'd4;

    bp_btb #(
        .BTB_BITS (BTB_BITS)
    ) u_btb (
        .clk         (clk),
        .clr_i       (state_q == INIT),
        .clr_idx_i   (init_idx_q[BTB_BITS-1:0]),
        .rd_pc_i     (lookup_pc_i),
        .rd_hit_o    (w_btb_hit),
        .rd_target_o (w_btb_target),
        .wr_en_i     (w_upd & update_taken_i),
        .wr_pc_i     (update_pc_i),
        .wr_target_i (update_target_i)
    );

    // A repair from EX always wins over the speculative shift of the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (w_accept && w_is_br) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], w_taken};
        end
        if (w_upd && update_mispredict_i) begin
            ghr_d = {update_ghr_i[GHR_BITS-2:0], update_taken_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            ready_q       <= 1'b0;
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
            pred_ghr_q    <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= w_accept;
            if (w_accept) begin
                pred_taken_q  <= w_taken;
                pred_hit_q    <= w_btb_hit;
                pred_target_q <= w_target;
                pred_ghr_q    <= ghr_q;
            end
            if (state_q == INIT) begin
                init_idx_q <= init_idx_q + INIT_BITS'(1);
                if (init_idx_q == '1) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            pht_q[init_idx_q[PHT_BITS-1:0]] <= WNT;
        end else if (w_upd && (update_opcode_i == OPC_BRANCH)) begin
            pht_q[w_up_idx] <= update_taken_i ? sat_inc(pht_q[w_up_idx])
                                              : sat_dec(pht_q[w_up_idx]);
        end
    end

    assign ready_o       = ready_q;
    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_hit_o    = pred_hit_q;
    assign pred_target_o = pred_target_q;
    assign pred_ghr_o    = pred_ghr_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
// +----------------------------------------------------------------------+
// | tb_branch_predictor_gshare: gshare and gselect instances driven in    |
// | lockstep, checked by a queue scoreboard against a table model.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_branch_predictor_gshare;

    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] ALU = 7'b0010011;

    typedef struct {
        bit          taken;
        bit          hit;
        logic [31:0] target;
        logic [7:0]  ghr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic [6:0]  opcode = '0;
    logic        update = 1'b0;
    logic [6:0]  update_opcode = '0;
    logic [31:0] update_pc = '0;
    logic [31:0] update_target = '0;
    logic        update_taken = 1'b0;
    logic [7:0]  update_ghr = '0;
    logic        update_mispredict = 1'b0;

    logic        rdy0, pv0, tk0, hit0, rdy1, pv1, tk1, hit1;
    logic [31:0] tgt0, tgt1;
    logic [7:0]  ghr0, ghr1;

    int tests = 0;
    int fails = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    bit          model_ready = 0;
    int unsigned pht_m [2][1024];
    int unsigned ghr_m [2];
    bit          btb_v   [64];
    logic [31:0] btb_tag [64];
    logic [31:0] btb_tgt [64];

    always #5 clk = ~clk;

    branch_predictor_gshare #(.PHT_BITS(10), .GHR_BITS(8), .BTB_BITS(6), .MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .lookup_valid_i(lookup_valid), .lookup_pc_i(lookup_pc),
        .opcode_i(opcode), .ready_o(rdy0), .pred_valid_o(pv0), .pred_taken_o(tk0),
        .pred_hit_o(hit0), .pred_target_o(tgt0), .pred_ghr_o(ghr0), .update_i(update),
        .update_opcode_i(update_opcode), .update_pc_i(update_pc),
        .update_target_i(update_target), .update_taken_i(update_taken),
        .update_ghr_i(update_ghr), .update_mispredict_i(update_mispredict)
    );

    branch_predictor_gshare #(.PHT_BITS(10), .GHR_BITS(8), .BTB_BITS(6), .MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .lookup_valid_i(lookup_valid), .lookup_pc_i(lookup_pc),
        .opcode_i(opcode), .ready_o(rdy1), .pred_valid_o(pv1), .pred_taken_o(tk1),
        .pred_hit_o(hit1), .pred_target_o(tgt1), .pred_ghr_o(ghr1), .update_i(update),
        .update_opcode_i(update_opcode), .update_pc_i(update_pc),
        .update_target_i(update_target), .update_taken_i(update_taken),
        .update_ghr_i(update_ghr), .update_mispredict_i(update_mispredict)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned pidx(input int m, input logic [31:0] pc, input int unsigned g);
        if (m == 0) return ((pc >> 2) % 1024) ^ g;
        return g * 4 + ((pc >> 2) % 4);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ghr_m[m] = 0;
            for (int i = 0; i < 1024; i++) pht_m[m][i] = 1;
        end
        for (int i = 0; i < 64; i++) btb_v[i] = 0;
        q0.delete();
        q1.delete();
    endtask

    // One cycle of predictor behaviour: predictions read the tables before any update lands.
    task automatic model_step(input bit lv, input logic [31:0] pc, input logic [6:0] opc,
                              input bit up, input logic [31:0] upc, input logic [31:0] utgt,
                              input bit utk, input logic [7:0] ughr, input bit umis,
                              input logic [6:0] uopc);
        int unsigned ghr_n [2];
        int unsigned bi, ui, c;
        bit hit, taken;
        exp_t e;
        bi  = (pc >> 2) % 64;
        hit = btb_v[bi] && (btb_tag[bi] == (pc >> 8));
        for (int m = 0; m < 2; m++) begin
            ghr_n[m] = ghr_m[m];
            if (lv) begin
                if (opc == BR)       taken = hit && (pht_m[m][pidx(m, pc, ghr_m[m])] >= 2);
                else if (opc == JAL) taken = hit;
                else                 taken = 0;
                e.taken  = taken;
                e.hit    = hit;
                e.target = taken ? btb_tgt[bi] : pc + 32'd4;
                e.ghr    = 8'(ghr_m[m]);
                if (m == 0) q0.push_back(e); else q1.push_back(e);
                if (opc == BR) ghr_n[m] = ((ghr_m[m] << 1) | taken) % 256;
            end
            if (up && umis) ghr_n[m] = ((ughr << 1) | utk) % 256;
            if (up && uopc == BR) begin
                ui = pidx(m, upc, ughr);
                c  = pht_m[m][ui];
                pht_m[m][ui] = utk ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
            end
        end
        if (up && utk) begin
            ui          = (upc >> 2) % 64;
            btb_v[ui]   = 1;
            btb_tag[ui] = upc >> 8;
            btb_tgt[ui] = utgt;
        end
        ghr_m = ghr_n;
    endtask

    task automatic step(input bit lv, input logic [31:0] pc, input logic [6:0] opc,
                        input bit up, input logic [31:0] upc, input logic [31:0] utgt,
                        input bit utk, input logic [7:0] ughr, input bit umis,
                        input logic [6:0] uopc);
        lookup_valid = lv; lookup_pc = pc; opcode = opc;
        update = up; update_pc = upc; update_target = utgt; update_taken = utk;
        update_ghr = ughr; update_mispredict = umis; update_opcode = uopc;
        if (model_ready) model_step(lv, pc, opc, up, upc, utgt, utk, ughr, umis, uopc);
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic [6:0] opc);
        step(1, pc, opc, 0, '0, '0, 0, '0, 0, BR);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                       input logic [7:0] g, input bit mis);
        step(0, '0, ALU, 1, pc, tgt, tk, g, mis, BR);
    endtask

    task automatic idle();
        step(0, '0, ALU, 0, '0, '0, 0, '0, 0, BR);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready0"}, {31'd0, rdy0}, 32'd0);
        chk({tag, "_ready1"}, {31'd0, rdy1}, 32'd0);
        chk({tag, "_pvalid0"}, {31'd0, pv0}, 32'd0);
        chk({tag, "_pvalid1"}, {31'd0, pv1}, 32'd0);
        chk({tag, "_outs0"}, {29'd0, tk0, hit0, |ghr0} | tgt0, 32'd0);
        chk({tag, "_outs1"}, {29'd0, tk1, hit1, |ghr1} | tgt1, 32'd0);
    endtask

    // Lookups and updates are thrown at the DUTs throughout INIT; none may take effect.
    task automatic init_phase(input string tag);
        bit early = 0;
        for (int i = 0; i < 1024; i++) begin
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0) early = 1;
            step($urandom_range(0, 1), 32'h100, BR, $urandom_range(0, 1), 32'h100,
                 32'h200, 1, 8'h00, 1, BR);
        end
        chk({tag, "_ready_low_1024"}, {31'd0, early}, 32'd0);
        chk({tag, "_ready_high0"}, {31'd0, rdy0}, 32'd1);
        chk({tag, "_ready_high1"}, {31'd0, rdy1}, 32'd1);
        model_ready = 1;
    endtask

    task automatic sb_pop(input int m, input logic pv, input logic tk, input logic ht,
                          input logic [31:0] tg, input logic [7:0] gh);
        exp_t e;
        if (pv !== 1'b1) return;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected_pred_valid%0d: got pred_valid=1, expected 0 at %0t", m, $time);
            return;
        end
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("pred_taken%0d", m), {31'd0, tk}, {31'd0, e.taken});
        chk($sformatf("pred_hit%0d", m), {31'd0, ht}, {31'd0, e.hit});
        chk($sformatf("pred_target%0d", m), tg, e.target);
        chk($sformatf("pred_ghr%0d", m), {24'd0, gh}, {24'd0, e.ghr});
    endtask

    always @(negedge clk) begin
        sb_pop(0, pv0, tk0, hit0, tgt0, ghr0);
        sb_pop(1, pv1, tk1, hit1, tgt1, ghr1);
    end

    initial begin
        logic [31:0] pc, upc;
        logic [6:0]  opc;
        int          r;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        init_phase("init");

        look(32'h100, BR);
        upd(32'h100, 32'h200, 1, 8'h00, 0);
        upd(32'h100, 32'h200, 1, 8'h00, 0);
        look(32'h100, BR);
        upd(32'h100, 32'h200, 0, 8'h00, 1);
        look(32'h100, BR);
        upd(32'h100, 32'h200, 0, 8'h00, 1);
        look(32'h100, BR);
        for (int g = 0; g < 4; g++) begin
            upd(32'h300, 32'h400, 1, 8'(g), 0);
            upd(32'h300, 32'h400, 1, 8'(g), 0);
        end
        upd(32'h300, 32'h400, 0, 8'h00, 1);
        look(32'h300, BR);
        look(32'h300, BR);
        look(32'h300, BR);
        step(1, 32'h300, BR, 1, 32'h300, 32'h0, 0, 8'h00, 1, BR);
        look(32'h300, BR);
        look(32'h200, BR);
        look(32'h300, JAL);
        look(32'h300, ALU);
        look(32'hFFFF_FFFC, BR);
        step(1, 32'h500, JAL, 1, 32'h500, 32'h800, 1, 8'h00, 0, JAL);
        look(32'h500, JAL);

        for (int n = 0; n < 2000; n++) begin
            pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
            upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
            r   = $urandom_range(0, 3);
            opc = (r < 2) ? BR : (r == 2) ? JAL : ALU;
            step($urandom_range(0, 1), pc, opc, $urandom_range(0, 1), upc,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
                 $urandom_range(0, 1) ? 8'(ghr_m[0]) : 8'($urandom),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 2) ? BR : JAL);
        end

        look(32'h100, BR);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_ready = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_phase("reinit");
        look(32'h100, BR);
        upd(32'h100, 32'h200, 1, 8'h00, 0);
        upd(32'h100, 32'h200, 1, 8'h00, 0);
        look(32'h100, BR);
        look(32'h100, BR);
        idle();
        idle();
        chk("sb_drain0", q0.size(), 32'd0);
        chk("sb_drain1", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
